// File: rtl/lock_pkg.sv
// Shared constants, state encodings and helpers for the keypad lock controller.
// Optional build macro ALARM_AUTOCLEAR_EN is consumed by lock_access_controller.
package lock_pkg;

  localparam int TICK_HZ           = 400;
  localparam int CLK_HZ            = 100_000_000;
  localparam int DEF_TICK_DIV      = CLK_HZ / TICK_HZ;
  localparam int DEF_MAX_FAIL      = 3;
  localparam int DEF_UNLOCK_TICKS  = 8000;
  localparam int DEF_IDLE_TICKS    = 4000;
  localparam int DEF_BEEP_TICKS    = 400;
  localparam int DEF_ALARM_TICKS   = 24000;

  localparam logic [3:0] ST_ENTRY    = 4'b0001;
  localparam logic [3:0] ST_UNLOCKED = 4'b0010;
  localparam logic [3:0] ST_ALARM    = 4'b0100;
  localparam logic [3:0] ST_ADMIN    = 4'b1000;

  // ADMIN_LOAD is the one-cycle key_load step; it still reports as ADMIN.
  typedef enum logic [2:0] {
    FSM_ENTRY      = 3'd0,
    FSM_UNLOCKED   = 3'd1,
    FSM_ALARM      = 3'd2,
    FSM_ADMIN      = 3'd3,
    FSM_ADMIN_LOAD = 3'd4
  } lock_fsm_e;

  function automatic logic [3:0] state_code(lock_fsm_e s);
    case (s)
      FSM_ENTRY:      state_code = ST_ENTRY;
      FSM_UNLOCKED:   state_code = ST_UNLOCKED;
      FSM_ALARM:      state_code = ST_ALARM;
      FSM_ADMIN:      state_code = ST_ADMIN;
      FSM_ADMIN_LOAD: state_code = ST_ADMIN;
      default:        state_code = ST_ENTRY;
    endcase
  endfunction

  function automatic logic [3:0] sat_inc4(logic [3:0] v);
    if (v == 4'hF) begin
      sat_inc4 = v;
    end else begin
      sat_inc4 = v + 4'd1;
    end
  endfunction

  function automatic int max4(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/lock_tick_gen.sv
// Parameterised clock divider producing a one-cycle tick enable every DIV cycles.
module lock_tick_gen #(
  parameter int DIV = 250000
) (
  input  logic clk_100Mhz,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] div_r;

  assign tick = (div_r == LAST);

  // Free-running divider that wraps to zero on the tick cycle.
  always_ff @(posedge clk_100Mhz or negedge reset) begin
    if (!reset) begin
      div_r <= CNT_W'(0);
    end else if (tick) begin
      div_r <= CNT_W'(0);
    end else begin
      div_r <= div_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lock_access_controller.sv
// Sequencing FSM for the 4-digit keypad lock: compare, unlock, alarm and admin programming.
// Define ALARM_AUTOCLEAR_EN to let ALARM clear itself after ALARM_TICKS ticks.
module lock_access_controller
  import lock_pkg::*;
#(
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int MAX_FAIL     = DEF_MAX_FAIL,
  parameter int UNLOCK_TICKS = DEF_UNLOCK_TICKS,
  parameter int IDLE_TICKS   = DEF_IDLE_TICKS,
  parameter int BEEP_TICKS   = DEF_BEEP_TICKS,
  parameter int ALARM_TICKS  = DEF_ALARM_TICKS
) (
  input  logic       clk_100Mhz,
  input  logic       reset,
  input  logic       confirm,
  input  logic       key_activity,
  input  logic       code_match,
  input  logic       operate,
  input  logic       administrate,
  input  logic       relieve,
  output logic [3:0] state,
  output logic       clear_entry,
  output logic       key_load,
  output logic       led_en,
  output logic       alarm,
  output logic [3:0] fail_count
);

  // One timer is shared by all states; it is sized for the longest interval.
  localparam int TIMER_W = $clog2(max4(UNLOCK_TICKS, IDLE_TICKS, BEEP_TICKS, ALARM_TICKS) + 1);
  localparam logic [TIMER_W-1:0] T_ZERO = TIMER_W'(0);
  localparam logic [TIMER_W-1:0] T_ONE  = TIMER_W'(1);

  lock_fsm_e          fsm_r, fsm_s;
  logic [TIMER_W-1:0] timer_r, timer_s;
  logic [TIMER_W-1:0] beep_r, beep_s;
  logic [3:0]         fail_s;
  logic               confirm_d_r, relieve_d_r;
  logic               confirm_edge_s, relieve_edge_s;
  logic               clear_s, load_s, alarm_s;
  logic               tick_s;

  lock_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk_100Mhz (clk_100Mhz),
    .reset      (reset),
    .tick       (tick_s)
  );

  assign confirm_edge_s = confirm & ~confirm_d_r;
  assign relieve_edge_s = relieve & ~relieve_d_r;

  // Next-state, timer and strobe decode.
  always_comb begin
    fsm_s   = fsm_r;
    timer_s = timer_r;
    fail_s  = fail_count;
    clear_s = 1'b0;
    load_s  = 1'b0;
    if (tick_s && (beep_r != T_ZERO)) begin
      beep_s = beep_r - T_ONE;
    end else begin
      beep_s = beep_r;
    end

    case (fsm_r)
      FSM_ENTRY: begin
        if (administrate) begin
          fsm_s   = FSM_ADMIN;
          clear_s = 1'b1;
          timer_s = T_ZERO;
        end else if (confirm_edge_s) begin
          clear_s = 1'b1;
          timer_s = T_ZERO;
          if (code_match) begin
            fsm_s  = FSM_UNLOCKED;
            fail_s = 4'd0;
          end else begin
            fail_s = sat_inc4(fail_count);
            beep_s = TIMER_W'(BEEP_TICKS);
            if (fail_s >= 4'(MAX_FAIL)) begin
              fsm_s = FSM_ALARM;
            end else begin
              fsm_s = FSM_ENTRY;
            end
          end
        end else if (key_activity) begin
          timer_s = T_ZERO;
        end else if (tick_s) begin
          if (timer_r >= TIMER_W'(IDLE_TICKS - 1)) begin
            clear_s = 1'b1;
            timer_s = T_ZERO;
          end else begin
            timer_s = timer_r + T_ONE;
          end
        end else begin
          timer_s = timer_r;
        end
      end

      FSM_UNLOCKED: begin
        if (administrate) begin
          fsm_s   = FSM_ADMIN;
          clear_s = 1'b1;
          timer_s = T_ZERO;
        end else if (confirm_edge_s) begin
          fsm_s   = FSM_ENTRY;
          clear_s = 1'b1;
          timer_s = T_ZERO;
        end else if (operate) begin
          timer_s = T_ZERO;
        end else if (tick_s) begin
          if (timer_r >= TIMER_W'(UNLOCK_TICKS - 1)) begin
            fsm_s   = FSM_ENTRY;
            clear_s = 1'b1;
            timer_s = T_ZERO;
          end else begin
            timer_s = timer_r + T_ONE;
          end
        end else begin
          timer_s = timer_r;
        end
      end

      FSM_ALARM: begin
        if (relieve_edge_s) begin
          fsm_s   = FSM_ENTRY;
          clear_s = 1'b1;
          fail_s  = 4'd0;
          timer_s = T_ZERO;
`ifdef ALARM_AUTOCLEAR_EN
        end else if (tick_s && (timer_r >= TIMER_W'(ALARM_TICKS - 1))) begin
          fsm_s   = FSM_ENTRY;
          clear_s = 1'b1;
          fail_s  = 4'd0;
          timer_s = T_ZERO;
        end else if (tick_s) begin
          timer_s = timer_r + T_ONE;
`endif
        end else begin
          timer_s = timer_r;
        end
      end

      FSM_ADMIN: begin
        timer_s = T_ZERO;
        if (!administrate) begin
          fsm_s  = FSM_ADMIN_LOAD;
          load_s = 1'b1;
        end else begin
          fsm_s = FSM_ADMIN;
        end
      end

      FSM_ADMIN_LOAD: begin
        fsm_s   = FSM_ENTRY;
        clear_s = 1'b1;
        fail_s  = 4'd0;
        timer_s = T_ZERO;
      end

      default: begin
        fsm_s   = FSM_ENTRY;
        clear_s = 1'b1;
        timer_s = T_ZERO;
      end
    endcase

    // A beep only lives in ENTRY; ALARM drives the buzzer on its own.
    if (fsm_s != FSM_ENTRY) begin
      beep_s = T_ZERO;
    end else begin
      beep_s = beep_s;
    end
    alarm_s = (fsm_s == FSM_ALARM) || (beep_s != T_ZERO);
  end

  // State, timers, edge detectors and registered outputs.
  always_ff @(posedge clk_100Mhz or negedge reset) begin
    if (!reset) begin
      fsm_r       <= FSM_ENTRY;
      timer_r     <= T_ZERO;
      beep_r      <= T_ZERO;
      confirm_d_r <= 1'b0;
      relieve_d_r <= 1'b0;
      state       <= ST_ENTRY;
      clear_entry <= 1'b0;
      key_load    <= 1'b0;
      led_en      <= 1'b0;
      alarm       <= 1'b0;
      fail_count  <= 4'd0;
    end else begin
      fsm_r       <= fsm_s;
      timer_r     <= timer_s;
      beep_r      <= beep_s;
      confirm_d_r <= confirm;
      relieve_d_r <= relieve;
      state       <= state_code(fsm_s);
      clear_entry <= clear_s;
      key_load    <= load_s;
      led_en      <= (fsm_s == FSM_UNLOCKED);
      alarm       <= alarm_s;
      fail_count  <= fail_s;
    end
  end

endmodule

// File: tb/tb_lock_access_controller.sv
// Directed scoreboard bench for lock_access_controller (honours ALARM_AUTOCLEAR_EN).
module tb_lock_access_controller;

  localparam logic [3:0] S_ENT = 4'b0001;
  localparam logic [3:0] S_UNL = 4'b0010;
  localparam logic [3:0] S_ALM = 4'b0100;
  localparam logic [3:0] S_ADM = 4'b1000;

  logic       clk_100Mhz = 1'b0;
  logic       reset = 1'b0;
  logic       confirm = 1'b0;
  logic       key_activity = 1'b0;
  logic       code_match = 1'b0;
  logic       operate = 1'b0;
  logic       administrate = 1'b0;
  logic       relieve = 1'b0;
  logic [3:0] state;
  logic       clear_entry;
  logic       key_load;
  logic       led_en;
  logic       alarm;
  logic [3:0] fail_count;

  int checks = 0;
  int errors = 0;
  int clr_cnt = 0;
  int kl_cnt = 0;
  int both_cnt = 0;

  typedef struct {
    string      tag;
    logic [3:0] st;
    logic [3:0] fc;
    logic       led;
    logic       alm;
  } exp_t;

  exp_t exp_q[$];

  lock_access_controller #(
    .TICK_DIV(4), .MAX_FAIL(3), .UNLOCK_TICKS(10), .IDLE_TICKS(6),
    .BEEP_TICKS(3), .ALARM_TICKS(8)
  ) dut (
    .clk_100Mhz   (clk_100Mhz),
    .reset        (reset),
    .confirm      (confirm),
    .key_activity (key_activity),
    .code_match   (code_match),
    .operate      (operate),
    .administrate (administrate),
    .relieve      (relieve),
    .state        (state),
    .clear_entry  (clear_entry),
    .key_load     (key_load),
    .led_en       (led_en),
    .alarm        (alarm),
    .fail_count   (fail_count)
  );

  always #5 clk_100Mhz = ~clk_100Mhz;

  always @(posedge clk_100Mhz) begin
    if (clear_entry === 1'b1) clr_cnt <= clr_cnt + 1;
    if (key_load === 1'b1) kl_cnt <= kl_cnt + 1;
    if (clear_entry === 1'b1 && key_load === 1'b1) both_cnt <= both_cnt + 1;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk_100Mhz);
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_range(string tag, int obs, int lo, int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic expect_out(string tag, logic [3:0] st, logic [3:0] fc, logic led, logic alm);
    exp_t e;
    e.tag = tag; e.st = st; e.fc = fc; e.led = led; e.alm = alm;
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_underflow", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, "_state"}, 32'(state), 32'(e.st));
      chk({e.tag, "_fail"}, 32'(fail_count), 32'(e.fc));
      chk({e.tag, "_led"}, 32'(led_en), 32'(e.led));
      chk({e.tag, "_alarm"}, 32'(alarm), 32'(e.alm));
    end
  endtask

  task automatic wait_state(string tag, logic [3:0] s, int max_cyc);
    int n = 0;
    while (state !== s && n < max_cyc) begin
      cyc(1);
      n++;
    end
    chk(tag, 32'(state), 32'(s));
  endtask

  initial begin
    int c0;
    int k0;
    int n;

    // Reset state
    cyc(3);
    expect_out("reset", S_ENT, 4'd0, 1'b0, 1'b0);
    check_out();
    chk("reset_clear", 32'(clear_entry), 32'd0);
    chk("reset_kload", 32'(key_load), 32'd0);
    reset = 1'b1;
    cyc(2);

    // Correct code, then auto-relock
    key_activity = 1'b1; cyc(1); key_activity = 1'b0; cyc(2);
    c0 = clr_cnt;
    code_match = 1'b1; confirm = 1'b1;
    expect_out("unlock", S_UNL, 4'd0, 1'b1, 1'b0);
    cyc(2);
    check_out();
    cyc(3);
    confirm = 1'b0;
    cyc(1);
    chk("unlock_clear", 32'(clr_cnt - c0), 32'd1);
    cyc(26);
    expect_out("unlock_hold", S_UNL, 4'd0, 1'b1, 1'b0);
    check_out();
    wait_state("relock", S_ENT, 20);
    chk("relock_led", 32'(led_en), 32'd0);

    // operate holds UNLOCKED; confirm relocks
    confirm = 1'b1; operate = 1'b1;
    expect_out("unlock2", S_UNL, 4'd0, 1'b1, 1'b0);
    cyc(2);
    check_out();
    confirm = 1'b0;
    cyc(60);
    expect_out("operate_hold", S_UNL, 4'd0, 1'b1, 1'b0);
    check_out();
    operate = 1'b0; confirm = 1'b1;
    expect_out("confirm_lock", S_ENT, 4'd0, 1'b0, 1'b0);
    cyc(2);
    check_out();
    confirm = 1'b0;
    cyc(1);

    // Three wrong codes
    code_match = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      confirm = 1'b1;
      expect_out($sformatf("wrong%0d", i), S_ENT, 4'(i), 1'b0, 1'b1);
      cyc(2);
      check_out();
      confirm = 1'b0;
      n = 0;
      while (alarm === 1'b1 && n < 40) begin
        cyc(1);
        n++;
      end
      chk_range($sformatf("beep%0d_len", i), n, 8, 13);
    end
    confirm = 1'b1;
    expect_out("alarm_enter", S_ALM, 4'd3, 1'b0, 1'b1);
    cyc(2);
    check_out();
    confirm = 1'b0;
    administrate = 1'b1;
    cyc(5);
    expect_out("alarm_admin", S_ALM, 4'd3, 1'b0, 1'b1);
    check_out();
    administrate = 1'b0;
    cyc(5);
`ifndef ALARM_AUTOCLEAR_EN
    cyc(60);
    expect_out("alarm_hold", S_ALM, 4'd3, 1'b0, 1'b1);
    check_out();
`endif
    c0 = clr_cnt;
    relieve = 1'b1;
    expect_out("relieve", S_ENT, 4'd0, 1'b0, 1'b0);
    cyc(2);
    check_out();
    cyc(3);
    relieve = 1'b0;
    cyc(1);
    chk("relieve_clear", 32'(clr_cnt - c0), 32'd1);

`ifdef ALARM_AUTOCLEAR_EN
    for (int i = 0; i < 3; i++) begin
      confirm = 1'b1; cyc(1); confirm = 1'b0; cyc(1);
    end
    cyc(1);
    expect_out("auto_alarm", S_ALM, 4'd3, 1'b0, 1'b1);
    check_out();
    cyc(18);
    expect_out("auto_hold", S_ALM, 4'd3, 1'b0, 1'b1);
    check_out();
    wait_state("autoclear", S_ENT, 30);
    chk("autoclear_fail", 32'(fail_count), 32'd0);
    chk("autoclear_alarm", 32'(alarm), 32'd0);
`endif

    // confirm held for 100 cycles counts once
    confirm = 1'b1;
    expect_out("held_once", S_ENT, 4'd1, 1'b0, 1'b1);
    cyc(2);
    check_out();
    cyc(98);
    confirm = 1'b0;
    cyc(1);
    expect_out("held_end", S_ENT, 4'd1, 1'b0, 1'b0);
    check_out();

    // Idle clear with restart near tick 5
    key_activity = 1'b1; cyc(1); key_activity = 1'b0;
    c0 = clr_cnt;
    cyc(19);
    chk("idle_early", 32'(clr_cnt - c0), 32'd0);
    key_activity = 1'b1; cyc(1); key_activity = 1'b0;
    cyc(19);
    chk("idle_restart", 32'(clr_cnt - c0), 32'd0);
    cyc(12);
    chk("idle_clear", 32'(clr_cnt - c0), 32'd1);
    expect_out("idle_fail", S_ENT, 4'd1, 1'b0, 1'b0);
    check_out();

    // confirm and administrate together: admin wins
    confirm = 1'b1; administrate = 1'b1;
    expect_out("simul_admin", S_ADM, 4'd1, 1'b0, 1'b0);
    cyc(2);
    check_out();
    confirm = 1'b0;
    cyc(3);
    k0 = kl_cnt;
    administrate = 1'b0;
    cyc(5);
    chk("admin_kload", 32'(kl_cnt - k0), 32'd1);
    expect_out("admin_exit", S_ENT, 4'd0, 1'b0, 1'b0);
    check_out();

    // Reset mid-ADMIN
    confirm = 1'b1; cyc(1); confirm = 1'b0; cyc(2);
    administrate = 1'b1;
    expect_out("admin2", S_ADM, 4'd1, 1'b0, 1'b0);
    cyc(2);
    check_out();
    k0 = kl_cnt;
    reset = 1'b0;
    #1;
    expect_out("mid_reset", S_ENT, 4'd0, 1'b0, 1'b0);
    check_out();
    chk("mid_reset_clear", 32'(clear_entry), 32'd0);
    chk("mid_reset_kload", 32'(key_load), 32'd0);
    cyc(3);
    administrate = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(5);
    chk("reset_no_kload", 32'(kl_cnt - k0), 32'd0);
    expect_out("post_reset", S_ENT, 4'd0, 1'b0, 1'b0);
    check_out();

    chk("never_both", 32'(both_cnt), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
